// File: rtl/char_pixel_renderer.sv
// rtl/char_pixel_renderer.sv - scaled 8x8 hex glyph renderer behind the VGA/LCD timing generator
// Optional frame border: define CHAR_PIXEL_RENDERER_BORDER_EN.
module char_pixel_renderer #(
    parameter int          SCALE_LOG2 = 4,
    parameter int          X0         = 176,
    parameter int          Y0         = 72,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic       vgaclk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hden,
    input  logic       vden,
    input  logic       clk3Hz,
    input  logic       start,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       de_out,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [3:0] glyph_idx
);
    localparam int         BOX   = 8 << SCALE_LOG2;
    localparam logic [8:0] X_MAX = 9'd479;
    localparam logic [8:0] Y_MAX = 9'd271;
    // One 64-bit word per digit; top row in the most significant byte, bit 7 of a row is leftmost.
    localparam logic [63:0] FONT [16] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
        64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
        64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000
    };

    logic       hden_q, vden_q, clk3_q, live_q;
    logic       pending_q, pending_d, synced_q, synced_d;
    logic [8:0] x_q, x_d, y_q, y_d;
    logic [3:0] glyph_q, glyph_d;
    logic       de, hfall, vrise, vfall, c3_rise;

    logic        de1_q, hs1_q, vs1_q, show1_q, box1_q;
    logic [7:0]  row1_q;
    logic [2:0]  col1_q;
    logic [3:0]  glyph1_q, glyph2_q;
    logic        de2_q, hs2_q, vs2_q;
    logic [23:0] rgb_q, rgb_d;
`ifdef CHAR_PIXEL_RENDERER_BORDER_EN
    logic        border1_q, border_s1;
`endif

    logic        in_box;
    logic [9:0]  x_rel, y_rel;
    logic [2:0]  col_s1, row_s1;
    logic [63:0] font_bits;
    logic [7:0]  font_row;

    assign de      = hden & vden;
    assign hfall   = hden_q & ~hden;
    // live_q masks the first cycle after reset so a frame already in progress is not taken as a frame start.
    assign vrise   = vden & ~vden_q & live_q;
    assign vfall   = vden_q & ~vden;
    assign c3_rise = clk3Hz & ~clk3_q;

    always_comb begin
        x_d = x_q;
        if (de) x_d = (x_q == X_MAX) ? X_MAX : x_q + 9'd1;
        else if (hfall) x_d = '0;

        y_d = y_q;
        if (vfall) y_d = '0;
        else if (hfall && vden && y_q != Y_MAX) y_d = y_q + 9'd1;

        glyph_d   = glyph_q;
        pending_d = pending_q;
        if (start) begin
            glyph_d   = '0;
            pending_d = 1'b0;
        end else if (vrise) begin
            if (pending_q) glyph_d = glyph_q + 4'd1;
            pending_d = c3_rise;
        end else if (c3_rise) begin
            pending_d = 1'b1;
        end

        synced_d = synced_q | vrise;
    end

    always_comb begin
        in_box    = (int'(x_q) >= X0) && (int'(x_q) < X0 + BOX) &&
                    (int'(y_q) >= Y0) && (int'(y_q) < Y0 + BOX);
        x_rel     = {1'b0, x_q} - 10'(X0);
        y_rel     = {1'b0, y_q} - 10'(Y0);
        col_s1    = 3'(x_rel >> SCALE_LOG2);
        row_s1    = 3'(y_rel >> SCALE_LOG2);
        font_bits = FONT[glyph_q];
        font_row  = font_bits[{~row_s1, 3'b000} +: 8];
`ifdef CHAR_PIXEL_RENDERER_BORDER_EN
        border_s1 = (x_q == '0) || (x_q == X_MAX) || (y_q == '0) || (y_q == Y_MAX);
`endif
    end

    always_comb begin
        rgb_d = '0;
        if (de1_q && show1_q) begin
            rgb_d = BG_COLOR;
`ifdef CHAR_PIXEL_RENDERER_BORDER_EN
            if (border1_q) rgb_d = 24'hFFFFFF;
            else
`endif
            if (box1_q && row1_q[~col1_q]) rgb_d = FG_COLOR;
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            hden_q <= 1'b0; vden_q <= 1'b0; clk3_q <= 1'b0; live_q <= 1'b0;
            pending_q <= 1'b0; synced_q <= 1'b0;
            x_q <= '0; y_q <= '0; glyph_q <= '0;
            de1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; show1_q <= 1'b0; box1_q <= 1'b0;
            row1_q <= '0; col1_q <= '0; glyph1_q <= '0;
            de2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0; rgb_q <= '0; glyph2_q <= '0;
`ifdef CHAR_PIXEL_RENDERER_BORDER_EN
            border1_q <= 1'b0;
`endif
        end else begin
            hden_q <= hden; vden_q <= vden; clk3_q <= clk3Hz; live_q <= 1'b1;
            pending_q <= pending_d; synced_q <= synced_d;
            x_q <= x_d; y_q <= y_d; glyph_q <= glyph_d;
            de1_q <= de; hs1_q <= hsync_in; vs1_q <= vsync_in;
            show1_q <= synced_q & ~start;
            box1_q <= in_box; row1_q <= font_row; col1_q <= col_s1; glyph1_q <= glyph_q;
            de2_q <= de1_q; hs2_q <= hs1_q; vs2_q <= vs1_q; rgb_q <= rgb_d; glyph2_q <= glyph1_q;
`ifdef CHAR_PIXEL_RENDERER_BORDER_EN
            border1_q <= border_s1;
`endif
        end
    end

    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign de_out    = de2_q;
    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];
    assign glyph_idx = glyph2_q;
endmodule

// File: doc/char_pixel_renderer.md
# char_pixel_renderer

Downstream stage of the VGA/LCD timing generator. Consumes the generator's `hsync`/`vsync`/`hden`/`vden`/`clk3Hz`/`start` outputs on the same `vgaclk`, and tracks the pixel position inside the 480x272 active window. Renders one scaled 8x8 hex glyph (0-F) as 24-bit RGB, stepping to the next glyph on each `clk3Hz` rising edge. Drives the panel with RGB and sync/enable signals delayed by exactly 2 cycles, so all panel signals stay aligned.

## Interface

Parameters:
- `SCALE_LOG2`, 4: glyph magnification = 2^SCALE_LOG2. Legal range 0..5.
- `X0`, 176: left column of the glyph box, in active pixels.
- `Y0`, 72: top line of the glyph box, in active lines.
- `FG_COLOR`, 24'hFFFFFF: RGB value for glyph "on" pixels.
- `BG_COLOR`, 24'h000000: RGB value for all other active pixels.

Ports:
- `vgaclk` in 1: pixel clock. Every register is clocked on its rising edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `hsync_in`, `vsync_in` in 1: syncs from the timing generator.
- `hden`, `vden` in 1: horizontal and vertical data enables.
- `clk3Hz` in 1: slow toggle from the timing generator, synchronous to `vgaclk`.
- `start` in 1: high while the generator outputs its initial black frames.
- `hsync_out`, `vsync_out` out 1: `hsync_in`/`vsync_in` delayed 2 cycles.
- `de_out` out 1: `(hden & vden)` delayed 2 cycles.
- `r`, `g`, `b` out 8 each: pixel colour.
- `glyph_idx` out 4: glyph currently being displayed.

## Operation

- **x counter (9 bit):**
  - Increments every cycle that `hden & vden` is high.
  - Clears on the cycle after `hden` falls.
  - Never exceeds 479. It saturates there if `hden` is held too long.
- **y counter (9 bit):**
  - Increments on each `hden` falling edge while `vden` is high.
  - Clears on the `vden` falling edge.
  - Saturates at 271.
- **synced flag:**
  - Cleared by reset.
  - Set on the first `vden` rising edge after reset.
  - While clear, `r`/`g`/`b` are 0.
- **Glyph box:** a pixel is in the box when `X0 <= x < X0 + (8<<SCALE_LOG2)` and likewise for y.
  - Glyph column = `(x-X0)>>SCALE_LOG2`; glyph row = `(y-Y0)>>SCALE_LOG2`.
  - The ROM supplies an 8-bit row pattern. Bit 7 is the leftmost column.
- **ROM:** an internal 16x8x8 constant ROM holding the hex digits 0-9 and A-F.
- **Colour select:**
  - `FG_COLOR` when in the box and the ROM bit = 1.
  - `BG_COLOR` for other active pixels.
  - 0 whenever `de` (delayed) = 0.
- **Glyph stepping:**
  - A `clk3Hz` rising edge (edge-detected with one register) sets `pending`.
  - On the next `vden` rising edge, `glyph_idx` becomes `glyph_idx+1` (wrapping 15 to 0) and `pending` clears. This prevents tearing.
  - If an edge and a `vden` rise occur in the same cycle, that edge is applied at the following frame start.
  - Multiple edges within one frame advance the glyph by only 1.
- **Start hold:**
  - While `start`=1: `glyph_idx` is held at 0, `pending` is held clear, and `r`/`g`/`b` = 0.
  - Syncs and `de_out` still pass through.

## Timing

- **Pipeline:** 2 stages.
  - Stage 1 registers the in-box flag, ROM row and column index.
  - Stage 2 registers the RGB output and the delayed sync/`de` signals.
- **Latency:** input to output is exactly 2 cycles for all outputs.
- **Reset values:** all outputs 0, including `glyph_idx` = 0. Counters, `pending`, synced flag and edge-detect registers are also 0.
- **Reset mid-frame:** outputs go to 0 immediately (asynchronous). After release, the pipeline refills within 2 cycles. Foreground stays suppressed until the next `vden` rise.

## Configuration

- **`CHAR_PIXEL_RENDERER_BORDER_EN` defined:** active pixels with x=0, x=479, y=0 or y=271 output 24'hFFFFFF. This overrides glyph and background colour, but is still gated by the synced flag and `start`.
- **Not defined:** no border logic is compiled in. Edge pixels follow the normal colour select.

## Test plan

- **Reset:** assert `rst` mid-line → `r`/`g`/`b`, `de_out`, `hsync_out`, `vsync_out` and `glyph_idx` read 0 in the same cycle. Foreground stays absent until the next `vden` rise.
- **Alignment:** run 2 full frames (`hden` 480 cycles, `vden` 272 lines) → `de_out` equals `hden & vden` delayed exactly 2 cycles. Expect 480x272 `de_out` cycles per frame.
- **Glyph render:** `glyph_idx`=0, defaults → pixel (176,72), which is the top-left of row 0 of "0", matches ROM bit 7. Pixels (175,72) and (304,72) are `BG_COLOR`. No `FG_COLOR` appears outside the box 176..303 x 72..199.
- **Stepping:** pulse `clk3Hz` high mid-frame → `glyph_idx` is unchanged until the next `vden` rise, then goes 0→1. Sixteen steps wrap 15→0. Two edges in one frame produce a single increment.
- **Start hold:** `start`=1 for 10 frames with `clk3Hz` toggling → `r`/`g`/`b` = 0 and `glyph_idx` = 0 throughout. After `start` falls, the first frame shows glyph 0.
- **Border (macro defined):** pixels (0,0), (479,135) and (240,271) output FFFFFF. With the macro undefined, the same pixels output `BG_COLOR`.
